// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Handles the multi-cycle imem handshake, decode stalls, redirects and halt.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_id,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        imem_err,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        if_id_err,
    output logic        halted
);

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_instr;
    logic [XLEN-1:0]   r_pc2;
    logic              r_valid;
    logic              r_err;
    logic              r_halted;
    logic [XLEN-1:0]   r_buf_instr;
    logic [XLEN-1:0]   r_buf_pc2;
    logic              r_buf_err;
    logic              r_halt_pending;

    state_t            w_state;
    logic [XLEN-1:0]   w_pc;
    logic [XLEN-1:0]   w_instr;
    logic [XLEN-1:0]   w_pc2;
    logic              w_valid;
    logic              w_err;
    logic [XLEN-1:0]   w_buf_instr;
    logic [XLEN-1:0]   w_buf_pc2;
    logic              w_buf_err;
    logic              w_halt_pending;
    logic              w_req;
    logic [XLEN-1:0]   w_pc_inc;
    logic [XLEN-1:0]   w_word;

    // A request is outstanding exactly while the FSM sits in FETCH or DRAIN.
    assign w_req    = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_pc_inc = r_pc + XLEN'(2);
    assign w_word   = imem_err ? NOP_INSTR : imem_rdata;

    always_comb begin
        w_state        = r_state;
        w_pc           = r_pc;
        w_instr        = r_instr;
        w_pc2          = r_pc2;
        w_valid        = r_valid;
        w_err          = r_err;
        w_buf_instr    = r_buf_instr;
        w_buf_pc2      = r_buf_pc2;
        w_buf_err      = r_buf_err;
        w_halt_pending = r_halt_pending;

        if ((r_state != S_HALTED) && redirect_valid) begin
            // Redirect squashes everything younger, including a same-cycle halt.
            w_pc           = redirect_pc;
            w_instr        = NOP_INSTR;
            w_valid        = 1'b0;
            w_err          = 1'b0;
            w_buf_instr    = NOP_INSTR;
            w_buf_pc2      = '0;
            w_buf_err      = 1'b0;
            w_halt_pending = 1'b0;
            w_state        = (w_req && !imem_done) ? S_DRAIN : S_FETCH;
        end else if ((r_state != S_HALTED) && halt_id && !stall_id) begin
            w_instr     = NOP_INSTR;
            w_valid     = 1'b0;
            w_err       = 1'b0;
            w_buf_instr = NOP_INSTR;
            w_buf_pc2   = '0;
            w_buf_err   = 1'b0;
            if (w_req && !imem_done) begin
                w_state        = S_DRAIN;
                w_halt_pending = 1'b1;
            end else begin
                w_state        = S_HALTED;
                w_halt_pending = 1'b0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_done) begin
                        w_pc = w_pc_inc;
                        if (stall_id) begin
                            w_buf_instr = w_word;
                            w_buf_pc2   = w_pc_inc;
                            w_buf_err   = imem_err;
                            w_state     = S_HOLD;
                        end else begin
                            w_instr = w_word;
                            w_pc2   = w_pc_inc;
                            w_valid = 1'b1;
                            w_err   = imem_err;
                        end
                    end else if (!stall_id) begin
                        w_instr = NOP_INSTR;
                        w_valid = 1'b0;
                        w_err   = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_id) begin
                        w_instr = r_buf_instr;
                        w_pc2   = r_buf_pc2;
                        w_valid = 1'b1;
                        w_err   = r_buf_err;
                        w_state = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    w_instr = NOP_INSTR;
                    w_valid = 1'b0;
                    w_err   = 1'b0;
                    if (imem_done) begin
                        w_state        = r_halt_pending ? S_HALTED : S_FETCH;
                        w_halt_pending = 1'b0;
                    end
                end
                S_HALTED: begin
                    w_instr = NOP_INSTR;
                    w_valid = 1'b0;
                    w_err   = 1'b0;
                end
                default: begin
                    w_state = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FETCH;
            r_pc           <= RESET_PC;
            r_instr        <= NOP_INSTR;
            r_pc2          <= '0;
            r_valid        <= 1'b0;
            r_err          <= 1'b0;
            r_halted       <= 1'b0;
            r_buf_instr    <= NOP_INSTR;
            r_buf_pc2      <= '0;
            r_buf_err      <= 1'b0;
            r_halt_pending <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_pc           <= w_pc;
            r_instr        <= w_instr;
            r_pc2          <= w_pc2;
            r_valid        <= w_valid;
            r_err          <= w_err;
            r_halted       <= (w_state == S_HALTED);
            r_buf_instr    <= w_buf_instr;
            r_buf_pc2      <= w_buf_pc2;
            r_buf_err      <= w_buf_err;
            r_halt_pending <= w_halt_pending;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc2   = r_pc2;
    assign if_id_valid = r_valid;
    assign if_id_err   = r_err;
    assign halted      = r_halted;

endmodule
